// File: rtl/ps2_joypad_decoder_pkg.sv
// Shared definitions for the PS/2 keyboard to NES joypad decoder.
// Holds scan-code constants, button bit indices, receiver FSM states and the
// key-to-button lookup used by the top-level decoder.
package ps2_joypad_decoder_pkg;

  // Receiver framing states
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Prefix bytes
  localparam logic [7:0] ScExt = 8'hE0;
  localparam logic [7:0] ScBrk = 8'hF0;

  // Key codes (arrows are only meaningful after the E0 prefix)
  localparam logic [7:0] ScKeyA      = 8'h22;  // X
  localparam logic [7:0] ScKeyB      = 8'h1A;  // Z
  localparam logic [7:0] ScKeySelect = 8'h59;  // right shift
  localparam logic [7:0] ScKeyStart  = 8'h5A;  // enter
  localparam logic [7:0] ScKeyUp     = 8'h75;
  localparam logic [7:0] ScKeyDown   = 8'h72;
  localparam logic [7:0] ScKeyLeft   = 8'h6B;
  localparam logic [7:0] ScKeyRight  = 8'h74;

  // Button bit positions in NES shift order
  localparam logic [2:0] BtnA      = 3'd0;
  localparam logic [2:0] BtnB      = 3'd1;
  localparam logic [2:0] BtnSelect = 3'd2;
  localparam logic [2:0] BtnStart  = 3'd3;
  localparam logic [2:0] BtnUp     = 3'd4;
  localparam logic [2:0] BtnDown   = 3'd5;
  localparam logic [2:0] BtnLeft   = 3'd6;
  localparam logic [2:0] BtnRight  = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } btn_map_t;

  // Extended and non-extended codes live in disjoint tables: keypad arrows
  // (no prefix) and keypad enter (E0 5A) deliberately miss.
  function automatic btn_map_t map_key(input logic ext, input logic [7:0] code);
    btn_map_t m;
    m.hit = 1'b1;
    m.idx = BtnA;
    if (!ext) begin
      case (code)
        ScKeyA:      m.idx = BtnA;
        ScKeyB:      m.idx = BtnB;
        ScKeySelect: m.idx = BtnSelect;
        ScKeyStart:  m.idx = BtnStart;
        default:     m.hit = 1'b0;
      endcase
    end else begin
      case (code)
        ScKeyUp:    m.idx = BtnUp;
        ScKeyDown:  m.idx = BtnDown;
        ScKeyLeft:  m.idx = BtnLeft;
        ScKeyRight: m.idx = BtnRight;
        default:    m.hit = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_joypad_decoder_rx.sv
// PS/2 receiver: synchronises and glitch-filters k_c/k_d, deframes 11-bit
// frames on filtered k_c falling edges and abandons stalled frames.
// Ports:
//   clk, rst        system clock, async active-low reset
//   k_c, k_d        raw PS/2 clock/data (asynchronous, idle high)
//   rx_byte         deframed byte (valid while rx_valid)
//   rx_valid        strobe: good frame in the current cycle
//   rx_perr         strobe: stop bit ok but odd parity failed
//   rx_ferr         strobe: bad stop bit or mid-frame timeout
module ps2_joypad_decoder_rx
  import ps2_joypad_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k_c,
  input  logic       k_d,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_perr,
  output logic       rx_ferr
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Bit 0 carries k_c, bit 1 carries k_d
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            filt_q, filt_d;
  logic [1:0][FiltW-1:0] fcnt_q, fcnt_d;
  logic                  kc_prev_q;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FiltW'(FILTER_LEN - 1)) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FiltW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      fcnt_q    <= '0;
      kc_prev_q <= 1'b1;
    end else begin
      sync1_q   <= {k_d, k_c};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      kc_prev_q <= filt_q[0];
    end
  end

  logic fall, kd;
  assign fall = kc_prev_q & ~filt_q[0];
  assign kd   = filt_q[1];

  rx_state_e       state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_hit, par_ok, in_stop;

  // An edge in the same cycle as expiry wins, so the frame keeps going
  assign tmo_hit = (state_q != StIdle) && !fall && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign par_ok  = ^{shift_q, parity_q};
  assign in_stop = fall && (state_q == StStop);

  assign rx_byte  = shift_q;
  assign rx_valid = in_stop && kd && par_ok;
  assign rx_perr  = in_stop && kd && !par_ok;
  assign rx_ferr  = (in_stop && !kd) || tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      if (state_q == StIdle || fall || tmo_hit) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      end

      if (fall) begin
        unique case (state_q)
          StIdle: begin
            if (!kd) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q   <= {kd, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= kd;
            state_q  <= StStop;
          end
          StStop: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end else if (tmo_hit) begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: rtl/ps2_joypad_decoder.sv
// PS/2 keyboard to NES joypad state decoder.
// Tracks E0/F0 prefixes over received bytes and maintains an 8-bit button
// word (1 = pressed) read by the memory controller as joycon state.
// Ports:
//   clk, rst     25 MHz system clock, async active-low reset
//   k_c, k_d     raw PS/2 clock/data
//   joy_state    buttons: A,B,Select,Start,Up,Down,Left,Right (bit0..7)
//   scan_code    last correctly framed byte
//   byte_valid   one-cycle pulse when scan_code updates
//   parity_err   one-cycle pulse on parity failure
//   frame_err    one-cycle pulse on bad stop bit or timeout
module ps2_joypad_decoder
  import ps2_joypad_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k_c,
  input  logic       k_d,
  output logic [7:0] joy_state,
  output logic [7:0] scan_code,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_perr, rx_ferr;

  ps2_joypad_decoder_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .k_c     (k_c),
    .k_d     (k_d),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_perr (rx_perr),
    .rx_ferr (rx_ferr)
  );

  logic [7:0] joy_q, joy_d, scan_q, scan_d;
  logic       valid_q, perr_q, ferr_q;
  logic       ext_q, ext_d, brk_q, brk_d;
  btn_map_t   map;

  always_comb begin
    joy_d  = joy_q;
    scan_d = scan_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    map    = map_key(ext_q, rx_byte);
    if (rx_valid) begin
      scan_d = rx_byte;
      if (rx_byte == ScExt) begin
        ext_d = 1'b1;
      end else if (rx_byte == ScBrk) begin
        brk_d = 1'b1;
      end else begin
        if (map.hit) joy_d[map.idx] = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else if (rx_perr || rx_ferr) begin
      // A corrupted byte may have been the key following a prefix
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      joy_q   <= '0;
      scan_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      joy_q   <= joy_d;
      scan_q  <= scan_d;
      valid_q <= rx_valid;
      perr_q  <= rx_perr;
      ferr_q  <= rx_ferr;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
    end
  end

  assign joy_state  = joy_q;
  assign scan_code  = scan_q;
  assign byte_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_joypad_decoder.sv
// Scoreboard bench for ps2_joypad_decoder: each frame sent pushes the output
// event it should produce; a negedge monitor pops and compares.
module tb_ps2_joypad_decoder;

  localparam logic [2:0] KValid = 3'b100;
  localparam logic [2:0] KPerr  = 3'b010;
  localparam logic [2:0] KFerr  = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       k_c = 1'b1;
  logic       k_d = 1'b1;
  logic [7:0] joy_state, scan_code;
  logic       byte_valid, parity_err, frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
    logic [7:0] joy;
  } exp_t;
  exp_t exp_q[$];

  ps2_joypad_decoder #(
    .FILTER_LEN    (2),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .k_c       (k_c),
    .k_d       (k_d),
    .joy_state (joy_state),
    .scan_code (scan_code),
    .byte_valid(byte_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    k_d = b;
    wait_clk(15);
    k_c = 1'b0;
    wait_clk(30);
    k_c = 1'b1;
    wait_clk(15);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit((~^data) ^ bad_par);
    send_bit(~bad_stop);
    k_d = 1'b1;
    wait_clk(10);
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [7:0] code, input logic [7:0] joy);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.joy  = joy;
    exp_q.push_back(e);
  endtask

  // Good bytes carry the expected code and button word
  task automatic send_good(input logic [7:0] code, input logic [7:0] joy);
    push_exp(KValid, code, joy);
    send_frame(code, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst && (byte_valid || parity_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {29'd0, byte_valid, parity_err, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("event_kind", {29'd0, byte_valid, parity_err, frame_err}, {29'd0, e.kind});
        if (e.kind == KValid) begin
          check_eq("scan_code", {24'd0, scan_code}, {24'd0, e.code});
          check_eq("joy_state", {24'd0, joy_state}, {24'd0, e.joy});
        end
      end
    end
  end

  initial begin
    wait_clk(3);
    check_eq("reset_joy", {24'd0, joy_state}, 32'd0);
    check_eq("reset_scan", {24'd0, scan_code}, 32'd0);
    check_eq("reset_pulses", {29'd0, byte_valid, parity_err, frame_err}, 32'd0);
    rst = 1'b1;
    wait_clk(5);

    // Press and release A
    send_good(8'h22, 8'h01);
    send_good(8'hF0, 8'h01);
    send_good(8'h22, 8'h00);

    // Up, Left, Start, then release Up
    send_good(8'hE0, 8'h00);
    send_good(8'h75, 8'h10);
    send_good(8'hE0, 8'h10);
    send_good(8'h6B, 8'h50);
    send_good(8'h5A, 8'h58);
    send_good(8'hE0, 8'h58);
    send_good(8'hF0, 8'h58);
    send_good(8'h75, 8'h48);

    // Parity error on B
    push_exp(KPerr, 8'h00, 8'h00);
    send_frame(8'h1A, 1'b1, 1'b0);
    check_eq("perr_joy_kept", {24'd0, joy_state}, 32'h48);

    // Bad stop after E0 drops the prefix: keypad 8 does nothing
    send_good(8'hE0, 8'h48);
    push_exp(KFerr, 8'h00, 8'h00);
    send_frame(8'h75, 1'b0, 1'b1);
    send_good(8'h75, 8'h48);

    // Truncated frame must time out exactly once
    push_exp(KFerr, 8'h00, 8'h00);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    k_d = 1'b1;
    wait_clk(250);
    check_eq("timeout_drained", exp_q.size(), 32'd0);
    send_good(8'h22, 8'h49);

    // Single-cycle glitches on idle clock line
    for (int g = 0; g < 4; g++) begin
      k_c = 1'b0;
      wait_clk(1);
      k_c = 1'b1;
      wait_clk(20);
    end
    check_eq("glitch_joy", {24'd0, joy_state}, 32'h49);
    check_eq("glitch_scan", {24'd0, scan_code}, 32'h22);

    // Reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    #1;
    check_eq("midrst_joy", {24'd0, joy_state}, 32'd0);
    check_eq("midrst_scan", {24'd0, scan_code}, 32'd0);
    check_eq("midrst_pulses", {29'd0, byte_valid, parity_err, frame_err}, 32'd0);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(5);
    send_good(8'h22, 8'h01);
    send_good(8'h1A, 8'h03);

    wait_clk(20);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_joypad_decoder.md
Name: ps2_joypad_decoder

Overview:
- Upstream input stage for the CPU joypad registers: samples the raw PS/2 keyboard lines (k_c, k_d) and deframes scan-code bytes.
- Tracks make/break and extended prefixes, and keeps an 8-bit NES-order button state word.
- The memory controller reads this word as the joycon 1/2 state.
- Runs on the 25 MHz system clk; replaces the existing keyboard-to-joypad converter with error reporting and timeout recovery.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before filtered k_c/k_d change (glitch filter).
- TIMEOUT_CYCLES, 25000: clk cycles (1 ms at 25 MHz) with no filtered k_c falling edge mid-frame before the frame is abandoned.

Ports:
- clk  input  1  system clock, 25 MHz
- rst  input  1  asynchronous active-low reset
- k_c  input  1  raw PS/2 clock, asynchronous, idle high
- k_d  input  1  raw PS/2 data, asynchronous, idle high
- joy_state  output  8  button state, 1=pressed; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
- scan_code  output  8  last correctly framed byte
- byte_valid  output  1  one-cycle pulse when scan_code updates
- parity_err  output  1  one-cycle pulse on odd-parity failure
- frame_err  output  1  one-cycle pulse on bad stop bit or timeout

Behaviour:
- Reset (rst low, asynchronous):
  - joy_state=0, scan_code=0, all pulses 0.
  - Synchronisers and filtered lines =1.
  - Rx FSM=IDLE; ext and brk flags cleared.
- Input conditioning:
  - 2-flop synchroniser per line.
  - Filter counter per line: the filtered value changes only after FILTER_LEN consecutive synchronised samples differ from it; any matching sample clears the counter.
  - A falling edge is filtered k_c 1->0 between consecutive cycles. All sampling uses filtered k_d on that edge.
- Rx FSM, advancing only on falling edges:
  - IDLE: k_d=0 -> DATA with bit_cnt=0. k_d=1 is ignored.
  - DATA: shift k_d into shift[7] (LSB first, right shift); bit_cnt increments; after the 8th bit -> PARITY.
  - PARITY: store k_d -> STOP.
  - STOP:
    - If k_d=1 and ^{shift,parity}=1 -> accept the byte.
    - If k_d=1 and the parity check fails -> parity_err.
    - If k_d=0 -> frame_err.
    - Always -> IDLE.
- Timeout:
  - The counter clears on every falling edge and while in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 without an edge gives frame_err, FSM -> IDLE, and clears ext/brk.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- Output latency:
  - byte_valid, scan_code, parity_err and frame_err register in the cycle after the stop-bit edge is detected.
  - joy_state updates in the same cycle as byte_valid.
- Byte decode (accepted bytes only):
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: apply the mapping, then clear ext and brk.
  - Mapping, non-extended: 0x22 (X)->A, 0x1A (Z)->B, 0x59 (RShift)->Select, 0x5A (Enter)->Start.
  - Mapping, extended: E0 75->Up, E0 72->Down, E0 6B->Left, E0 74->Right.
  - Press sets the mapped bit; brk clears it.
  - Non-extended 0x75/0x72/0x6B/0x74 (keypad) and unmapped codes change nothing.
  - Extended 0x5A (keypad Enter) does not map to Start.
- Errored bytes: parity or frame errors discard the byte and clear ext and brk. joy_state is untouched.
- Repeated make codes (typematic) are idempotent.
- No opposite-direction masking: Up+Down may both be set.
- Reset mid-frame: returns to IDLE with the reset values listed above. The partial frame is never delivered.

Decomposition:
- Shared include ps2_defs.vh holds:
  - Scan-code constants: SC_EXT=8'hE0, SC_BRK=8'hF0, the eight key codes above.
  - Button bit indices: BTN_A=0 .. BTN_RIGHT=7.
  - FSM state encodings: IDLE, DATA, PARITY, STOP.
- Sub-module ps2_rx: synchronisers, glitch filters, framing FSM and timeout.
  - Outputs: rx_byte, rx_valid, rx_perr, rx_ferr.
- The top of ps2_joypad_decoder holds the prefix flags and the button register.

Test Plan (bench FILTER_LEN=2, TIMEOUT_CYCLES=200, PS/2 bit period 60 clk):
- Reset, then send frame 0x22 (parity 1) -> byte_valid pulse, scan_code=8'h22, joy_state=8'h01.
- Send F0 then 22 -> two byte_valid pulses; joy_state=8'h00 after the second.
- Send E0 75, E0 6B, then 0x5A -> joy_state=8'h58; then E0 F0 75 -> joy_state=8'h48.
- Send 0x1A with wrong parity -> parity_err pulse, no byte_valid, joy_state unchanged. Then E0 followed by a bad-stop frame, then 0x75 -> frame_err pulse; 0x75 is treated as non-extended, joy_state unchanged.
- Drive start + 3 data bits, then hold k_c high 250 clk -> frame_err exactly once, FSM IDLE; a following clean 0x22 frame decodes correctly.
- Inject 1-cycle low glitches on k_c while idle -> no state change. Assert rst mid-frame -> all outputs 0 immediately; the next full frame decodes.
